imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter DATA_W, default 32: immediate output width.
REQ-002 Parameter OPC_W, default 5: opcode width; the format table holds 2**OPC_W entries.
REQ-003 Parameter P1_W, default 5: short immediate field width.
REQ-004 Parameter P2_W, default 10: long immediate field width; the block SHALL require P1_W < P2_W <= DATA_W.
REQ-005 Clocking SHALL be one clock `clk`, with reset `rst_n` asynchronous and active-low.
REQ-006 Port list (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: block can accept an instruction.
- `in_opc` in OPC_W: opcode.
- `in_p1` in P1_W: short field.
- `in_p2` in P2_W: long field.
- `flush` in 1: discard all held entries.
- `cfg_we` in 1: format table write strobe.
- `cfg_opc` in OPC_W: table index.
- `cfg_fmt` in 3: format code written.
- `out_valid` out 1: immediate valid.
- `out_ready` in 1: consumer accepts.
- `out_imm` out DATA_W: generated immediate.
- `out_fmt` out 3: format code applied.
- `out_illegal` out 1: reserved format was applied.

Function
REQ-007 Format codes SHALL be as follows; codes 6 and 7 SHALL be reserved, produce zero and set out_illegal.
- 0 ZERO: all zeros.
- 1 SHORT_ZX: p1 zero-extended.
- 2 SHORT_SX: p1 sign-extended.
- 3 LONG_ZX: p2 zero-extended.
- 4 LONG_SX: p2 sign-extended.
- 5 LONG_HI: p2 placed in the top P2_W bits, lower bits zero.
REQ-008 The table SHALL be indexed by in_opc at acceptance; the immediate is computed at acceptance and stored with its format.
REQ-009 An instruction SHALL be accepted when in_valid and in_ready are both 1.
REQ-010 Output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-011 Storage SHALL be a 2-entry FIFO (output register plus skid register).
REQ-012 in_ready SHALL be 1 when fewer than 2 entries are held, combinationally independent of out_ready.
REQ-013 Latency SHALL be 1 cycle: an instruction accepted at cycle N into an empty block gives out_valid=1 at N+1.
REQ-014 Back-to-back throughput SHALL be 1 per cycle while out_ready=1.
REQ-015 With 2 entries held, in_ready SHALL be 0.
REQ-016 Simultaneous accept and output transfer SHALL leave the occupancy unchanged and preserve order.
REQ-017 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-018 flush=1 SHALL empty the FIFO at the next edge, so out_valid=0 the following cycle.
REQ-019 An instruction presented in the same cycle as flush SHALL be dropped; in_ready is unaffected by flush in that cycle.
REQ-020 flush SHALL NOT alter the table.
REQ-021 A cfg_we write SHALL take effect at the next edge.
REQ-022 An instruction accepted in the same cycle as a write to its opcode SHALL use the pre-write format.
REQ-023 Entries already held SHALL NOT be recomputed after a table write.
REQ-024 Sign extension SHALL replicate bit 0, the MSB in the team's [0:N] ascending bit ordering, of the field.

Reset
REQ-025 rst_n=0 SHALL immediately force:
- out_valid=0, out_imm=0, out_fmt=0, out_illegal=0;
- occupancy to 0;
- in_ready=1 (after release).
REQ-026 Reset SHALL load the table with the default map:
- 11000 -> LONG_ZX;
- 11001, 10001, 10011, 10010, 11101 -> SHORT_ZX;
- all other opcodes -> ZERO.
REQ-027 Reset asserted mid-stream SHALL discard all held entries without emitting them.

Structure
REQ-028 A shared package SHALL hold:
- the 3-bit format enum (FMT_ZERO .. FMT_LONG_HI, reserved values);
- the default-map opcode constants.
REQ-029 The combinational extend logic SHALL be a sub-module `imm_extend` (inputs fmt, p1, p2; outputs imm, illegal), instantiated once at the input.

Verification
REQ-030 Default map: accept opc=11000, p2=10'h3FF -> next cycle out_imm=32'h000003FF, out_fmt=3.
REQ-031 Sign extension: cfg write opc=11001 fmt=2, then opc=11001, p1=5'b10000 -> out_imm=32'hFFFFFFF0.
REQ-032 Backpressure: out_ready=0 with 3 consecutive valid inputs A, B, C.
- Required: in_ready=0 after A and B are held; out_imm holds A.
- Required: release emits A, B, C in order with no loss.
REQ-033 Same-cycle config: write fmt=5 to 10001 while accepting 10001, p1=5'h1F, p2=10'h001.
- First result: 32'h0000001F.
- Next 10001 with p2=10'h001: 32'h00400000.
REQ-034 Flush and reset: two entries held, pulse flush -> out_valid=0 next cycle; with opc=00000 -> out_imm=0, out_illegal=0.
REQ-035 Reset and reserved format:
- Assert rst_n=0 while an entry is held -> out_valid=0 at once.
- After release, cfg fmt=7 on any opcode and accept it -> out_illegal=1, out_imm=0.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// imm_gen_stage_pkg: format codes and reset-time opcode map for the immediate generator.
package imm_gen_stage_pkg;
  typedef enum logic [2:0] {
    FMT_ZERO     = 3'd0,
    FMT_SHORT_ZX = 3'd1,
    FMT_SHORT_SX = 3'd2,
    FMT_LONG_ZX  = 3'd3,
    FMT_LONG_SX  = 3'd4,
    FMT_LONG_HI  = 3'd5,
    FMT_RSV6     = 3'd6,
    FMT_RSV7     = 3'd7
  } fmt_e;
  localparam logic [4:0] OPC_LONG_ZX  = 5'b11000;
  localparam logic [4:0] OPC_SHORT_A  = 5'b11001;
  localparam logic [4:0] OPC_SHORT_B  = 5'b10001;
  localparam logic [4:0] OPC_SHORT_C  = 5'b10011;
  localparam logic [4:0] OPC_SHORT_D  = 5'b10010;
  localparam logic [4:0] OPC_SHORT_E  = 5'b11101;
  function automatic fmt_e default_fmt(input int opc);
    return opc == int'(OPC_LONG_ZX) ? FMT_LONG_ZX :
           (opc == int'(OPC_SHORT_A) || opc == int'(OPC_SHORT_B) || opc == int'(OPC_SHORT_C) ||
            opc == int'(OPC_SHORT_D) || opc == int'(OPC_SHORT_E)) ? FMT_SHORT_ZX : FMT_ZERO;
  endfunction
endpackage

// File: rtl/imm_gen_stage_extend.sv
// imm_extend: combinational immediate build from a format code and the two fields.
module imm_extend
  import imm_gen_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int P1_W   = 5,
  parameter int P2_W   = 10
) (
  input  fmt_e              fmt,
  input  logic [0:P1_W-1]   p1,
  input  logic [0:P2_W-1]   p2,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);
  // fields are ascending-ordered, so bit 0 is the sign bit picked up by $signed
  logic [DATA_W-1:0] p1_zx, p1_sx, p2_zx, p2_sx, p2_hi;
  assign p1_zx = DATA_W'(p1);
  assign p1_sx = DATA_W'($signed(p1));
  assign p2_zx = DATA_W'(p2);
  assign p2_sx = DATA_W'($signed(p2));
  assign p2_hi = p2_zx << (DATA_W - P2_W);
  assign illegal = fmt inside {FMT_RSV6, FMT_RSV7};
  assign imm = fmt == FMT_SHORT_ZX ? p1_zx :
               fmt == FMT_SHORT_SX ? p1_sx :
               fmt == FMT_LONG_ZX  ? p2_zx :
               fmt == FMT_LONG_SX  ? p2_sx :
               fmt == FMT_LONG_HI  ? p2_hi : '0;
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: table-driven immediate generator with a 2-entry output FIFO.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5,
  parameter int P1_W   = 5,
  parameter int P2_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opc,
  input  logic [0:P1_W-1]   in_p1,
  input  logic [0:P2_W-1]   in_p2,
  input  logic              flush,
  input  logic              cfg_we,
  input  logic [OPC_W-1:0]  cfg_opc,
  input  logic [2:0]        cfg_fmt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal
);
  localparam int E_W = DATA_W + 4;
  if (!(P1_W < P2_W && P2_W <= DATA_W)) begin : g_bad_params
    $error("imm_gen_stage: need P1_W < P2_W <= DATA_W");
  end
  fmt_e              tbl_q [2**OPC_W];
  fmt_e              in_fmt;
  logic [DATA_W-1:0] ext_imm;
  logic              ext_illegal;
  logic [E_W-1:0]    new_e, head_q, head_d, skid_q, skid_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;
  assign in_fmt = tbl_q[in_opc];
  imm_extend #(.DATA_W(DATA_W), .P1_W(P1_W), .P2_W(P2_W)) u_ext (
    .fmt(in_fmt), .p1(in_p1), .p2(in_p2), .imm(ext_imm), .illegal(ext_illegal)
  );
  assign new_e       = {ext_illegal, 3'(in_fmt), ext_imm};
  assign in_ready    = cnt_q != 2'd2;
  assign out_valid   = cnt_q != 2'd0;
  assign out_imm     = head_q[DATA_W-1:0];
  assign out_fmt     = head_q[DATA_W+:3];
  assign out_illegal = head_q[E_W-1];
  assign push        = in_valid & in_ready & ~flush;
  assign pop         = out_valid & out_ready;
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (cnt_q == 2'd2) begin
      if (pop) begin
        head_d = skid_q;
        cnt_d  = 2'd1;
      end
    end else if (push) begin
      // an empty FIFO or one draining this cycle loads the head; otherwise skid
      if (cnt_q == 2'd0 || pop) begin
        head_d = new_e;
        cnt_d  = 2'd1;
      end else begin
        skid_d = new_e;
        cnt_d  = 2'd2;
      end
    end else if (pop) begin
      cnt_d = 2'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
  // a write lands after this edge's lookup, so a same-cycle accept sees the old format
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**OPC_W; i++) tbl_q[i] <= default_fmt(i);
    end else if (cfg_we) begin
      tbl_q[cfg_opc] <= fmt_e'(cfg_fmt);
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed vectors with hand-computed immediates for imm_gen_stage.
module tb_imm_gen_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, cfg_we, out_valid, out_ready, out_illegal;
  logic [4:0]  in_opc, cfg_opc;
  logic [0:4]  in_p1;
  logic [0:9]  in_p2;
  logic [2:0]  cfg_fmt, out_fmt;
  logic [31:0] out_imm;
  int checks = 0;
  int errors = 0;
  imm_gen_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .in_p1(in_p1), .in_p2(in_p2), .flush(flush), .cfg_we(cfg_we), .cfg_opc(cfg_opc),
    .cfg_fmt(cfg_fmt), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] opc, input logic [0:4] p1, input logic [0:9] p2);
    in_valid = v;
    in_opc   = opc;
    in_p1    = p1;
    in_p2    = p2;
  endtask
  task automatic cfg(input logic [4:0] opc, input logic [2:0] fmt);
    cfg_we  = 1'b1;
    cfg_opc = opc;
    cfg_fmt = fmt;
    step();
    cfg_we  = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_opc = '0; cfg_fmt = '0; out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 10'd0);
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_fmt", 32'(out_fmt), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    // default map, long zero-extend, 1-cycle latency
    drive(1'b1, 5'b11000, 5'd0, 10'h3FF); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("def_long_valid", 32'(out_valid), 32'd1);
    chk("def_long_imm", out_imm, 32'h0000_03FF);
    chk("def_long_fmt", 32'(out_fmt), 32'd3);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 5'b10010, 5'h15, 10'h3FF); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("def_short_imm", out_imm, 32'h0000_0015);
    chk("def_short_fmt", 32'(out_fmt), 32'd1);
    drive(1'b1, 5'b00101, 5'h1F, 10'h3FF); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("def_zero_imm", out_imm, 32'd0);
    chk("def_zero_fmt", 32'(out_fmt), 32'd0);
    step();
    // sign extension from field bit 0
    cfg(5'b11001, 3'd2);
    drive(1'b1, 5'b11001, 5'b10000, 10'd0); step();
    chk("sx_neg_imm", out_imm, 32'hFFFF_FFF0);
    chk("sx_neg_fmt", 32'(out_fmt), 32'd2);
    drive(1'b1, 5'b11001, 5'b01111, 10'd0); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("sx_pos_imm", out_imm, 32'h0000_000F);
    cfg(5'b00011, 3'd4);
    drive(1'b1, 5'b00011, 5'd0, 10'h200); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("lsx_imm", out_imm, 32'hFFFF_FE00);
    step();
    // backpressure: A, B held, C waits
    out_ready = 1'b0;
    drive(1'b1, 5'b11000, 5'd0, 10'd1); step();
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    chk("bp_a_imm", out_imm, 32'd1);
    drive(1'b1, 5'b11000, 5'd0, 10'd2); step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", out_imm, 32'd1);
    drive(1'b1, 5'b11000, 5'd0, 10'd3); step();
    chk("bp_stall_imm", out_imm, 32'd1);
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; step();
    chk("bp_emit_b", out_imm, 32'd2);
    step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("bp_emit_c", out_imm, 32'd3);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    // back-to-back stream at full rate
    for (int i = 4; i < 7; i++) begin
      drive(1'b1, 5'b11000, 5'd0, 10'(i)); step();
      chk("b2b_imm", out_imm, 32'(i));
      chk("b2b_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 5'd0, 5'd0, 10'd0); step();
    // same-cycle config write uses the old format
    cfg_we = 1'b1; cfg_opc = 5'b10001; cfg_fmt = 3'd5;
    drive(1'b1, 5'b10001, 5'h1F, 10'h001); step(); cfg_we = 1'b0;
    chk("samecfg_old", out_imm, 32'h0000_001F);
    chk("samecfg_old_fmt", 32'(out_fmt), 32'd1);
    step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("samecfg_new", out_imm, 32'h0040_0000);
    chk("samecfg_new_fmt", 32'(out_fmt), 32'd5);
    step();
    // flush with two entries held
    out_ready = 1'b0;
    drive(1'b1, 5'b00000, 5'h1F, 10'h3FF); step(); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 5'b11000, 5'd0, 10'h0AA); flush = 1'b1; #1;
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    step(); flush = 1'b0;
    chk("fl_drop", 32'(out_valid), 32'd0);
    drive(1'b1, 5'b00000, 5'h1F, 10'h3FF); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("fl_zero_valid", 32'(out_valid), 32'd1);
    chk("fl_zero_imm", out_imm, 32'd0);
    chk("fl_zero_illegal", 32'(out_illegal), 32'd0);
    out_ready = 1'b1; step();
    drive(1'b1, 5'b11001, 5'b10000, 10'd0); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("fl_tbl_kept", out_imm, 32'hFFFF_FFF0);
    // async reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 5'b11000, 5'd0, 10'h055); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("ar_held", 32'(out_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_imm", out_imm, 32'd0);
    step(); rst_n = 1'b1; out_ready = 1'b1;
    chk("ar_no_emit", 32'(out_valid), 32'd0);
    drive(1'b1, 5'b11001, 5'b10000, 10'd0); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("ar_tbl_default", out_imm, 32'h0000_0010);
    chk("ar_tbl_fmt", 32'(out_fmt), 32'd1);
    // reserved format
    cfg(5'b00111, 3'd7);
    drive(1'b1, 5'b00111, 5'h1F, 10'h3FF); step(); drive(1'b0, 5'd0, 5'd0, 10'd0);
    chk("rsv_illegal", 32'(out_illegal), 32'd1);
    chk("rsv_imm", out_imm, 32'd0);
    chk("rsv_fmt", 32'(out_fmt), 32'd7);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
